// File: rtl/cam_frame_capture.sv
// cam_frame_capture: OV7670 RGB565 byte stream to RGB111/RGB332 framebuffer writer.
// Captures one frame aligned to VSYNC on request, or zero-fills the buffer.
module cam_frame_capture #(
  parameter int AW      = 15,
  parameter int H_PIX   = 176,
  parameter int V_LINES = 144,
  parameter int DW      = 3
) (
  input  logic          P_clk,
  input  logic          rst_n,
  input  logic          capture_req,
  input  logic          fill_req,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    D,
  output logic          regwrite,
  output logic [DW-1:0] data_w,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          frame_done,
  output logic          short_frame
);

  localparam int TOTAL = H_PIX * V_LINES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(H_PIX + 1);
  localparam int YW    = $clog2(V_LINES + 1);

  localparam logic [CW-1:0] TOT  = CW'(TOTAL);
  localparam logic [XW-1:0] HMAX = XW'(H_PIX);
  localparam logic [YW-1:0] VMAX = YW'(V_LINES);

  typedef enum logic [2:0] {
    IDLE, SYNC, CAPTURE, FILL, DONE
  } state_t;

  state_t state, nxt;

  logic          vs_r, hr_r, vs_q, hr_q;
  logic [7:0]    d_r, b0;
  logic          phase, seen_vs;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [AW-1:0] base;
  logic [CW-1:0] cnt;
  logic          pix_v;
  logic [DW-1:0] pix_d;
  logic [AW-1:0] pix_a;
  logic [DW-1:0] fmt;

  logic accept, in_cap, vs_rise, hr_fall;
  logic pix_done, keep, fill_we;
  logic unused_bits;

  assign accept   = (state == IDLE) && (fill_req || capture_req);
  assign in_cap   = (state == CAPTURE);
  assign vs_rise  = vs_r && !vs_q;
  assign hr_fall  = hr_q && !hr_r;
  assign pix_done = in_cap && hr_r && phase;
  assign keep     = (col < HMAX) && (row < VMAX);
  assign fill_we  = (state == FILL) && (cnt != TOT);

  assign unused_bits = ^{d_r, b0};

  if (DW == 8) begin : g_rgb332
    assign fmt = {b0[7:5], b0[2:0], d_r[4:3]};
  end else begin : g_rgb111
    assign fmt = {b0[7], b0[2], d_r[4]};
  end

  always_ff @(posedge P_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (fill_req)         nxt = FILL;
        else if (capture_req) nxt = SYNC;
      end
      SYNC:    if (seen_vs && !vs_r)         nxt = CAPTURE;
      CAPTURE: if ((cnt == TOT) || vs_rise)  nxt = DONE;
      FILL:    if (cnt == TOT)               nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  always_ff @(posedge P_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r <= 1'b0;
      hr_r <= 1'b0;
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= VSYNC;
      hr_r <= HREF;
      vs_q <= vs_r;
      hr_q <= hr_r;
      d_r  <= D;
    end
  end

  always_ff @(posedge P_clk or negedge rst_n) begin
    if (!rst_n) begin
      b0          <= '0;
      phase       <= 1'b0;
      seen_vs     <= 1'b0;
      col         <= '0;
      row         <= '0;
      base        <= '0;
      cnt         <= '0;
      pix_v       <= 1'b0;
      pix_d       <= '0;
      pix_a       <= '0;
      short_frame <= 1'b0;
    end else if (accept) begin
      phase       <= 1'b0;
      seen_vs     <= 1'b0;
      col         <= '0;
      row         <= '0;
      base        <= '0;
      cnt         <= '0;
      pix_v       <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      seen_vs <= (state == SYNC) && (seen_vs || vs_r);
      phase   <= in_cap && hr_r && !phase;
      if (in_cap && hr_r && !phase)
        b0 <= d_r;
      pix_v <= pix_done && keep;
      if (pix_done) begin
        pix_d <= fmt;
        pix_a <= base + AW'(col);
        if (col != HMAX) col <= col + XW'(1);
      end
      // Unpadded short lines still advance the row stride.
      if (in_cap && hr_fall) begin
        col <= '0;
        if (col != '0) begin
          if (row != VMAX) row <= row + YW'(1);
          base <= base + AW'(H_PIX);
          if (keep) short_frame <= 1'b1;
        end
      end
      if (in_cap && vs_rise && (cnt != TOT))
        short_frame <= 1'b1;
      if (fill_we || (in_cap && pix_v))
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge P_clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      data_w   <= '0;
      addr     <= '0;
    end else begin
      regwrite <= fill_we || (in_cap && pix_v);
      if (fill_we) begin
        data_w <= '0;
        addr   <= AW'(cnt);
      end else if (pix_v) begin
        data_w <= pix_d;
        addr   <= pix_a;
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb_cam_frame_capture: scoreboard bench, 4x2 geometry, RGB111 and RGB332 instances.
// Expected writes are queued as camera bytes are driven and popped on regwrite.
module tb_cam_frame_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic       P_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       capture_req = 1'b0;
  logic       fill_req = 1'b0;
  logic       VSYNC = 1'b0;
  logic       HREF = 1'b0;
  logic [7:0] D = 8'h00;

  logic        regwrite, busy, frame_done, short_frame;
  logic [2:0]  data_w;
  logic [14:0] addr;
  logic        regwrite8, busy8, frame_done8, short_frame8;
  logic [7:0]  data_w8;
  logic [14:0] addr8;

  cam_frame_capture #(.AW(15), .H_PIX(H), .V_LINES(V), .DW(3)) dut (
    .P_clk(P_clk), .rst_n(rst_n),
    .capture_req(capture_req), .fill_req(fill_req),
    .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .regwrite(regwrite), .data_w(data_w), .addr(addr),
    .busy(busy), .frame_done(frame_done), .short_frame(short_frame)
  );

  cam_frame_capture #(.AW(15), .H_PIX(H), .V_LINES(V), .DW(8)) dut8 (
    .P_clk(P_clk), .rst_n(rst_n),
    .capture_req(capture_req), .fill_req(fill_req),
    .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .regwrite(regwrite8), .data_w(data_w8), .addr(addr8),
    .busy(busy8), .frame_done(frame_done8), .short_frame(short_frame8)
  );

  always #5 P_clk = ~P_clk;

  typedef struct {
    int a;
    int d;
  } exp_t;

  exp_t q3[$];
  exp_t q8[$];
  exp_t e3, e8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wr  = 0;
  int done_cnt = 0;
  int done_gap = 0;
  int mrow     = 0;
  int mcol     = 0;
  int base     = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int f3(input logic [7:0] b0, input logic [7:0] b1);
    logic [2:0] p;
    p = {b0[7], b0[2], b1[4]};
    return int'(p);
  endfunction

  function automatic int f8(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] p;
    p = {b0[7:5], b0[2:0], b1[4:3]};
    return int'(p);
  endfunction

  task automatic push(input int a, input int d3, input int d8);
    q3.push_back('{a: a, d: d3});
    q8.push_back('{a: a, d: d8});
  endtask

  always begin
    @(posedge P_clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (regwrite) begin
        if (q3.size() == 0) begin
          check("wr3_unexpected", int'(addr), -1);
        end else begin
          e3 = q3.pop_front();
          check("wr3_addr", int'(addr), e3.a);
          check("wr3_data", int'(data_w), e3.d);
        end
        last_wr = cyc;
      end
      if (regwrite8) begin
        if (q8.size() == 0) begin
          check("wr8_unexpected", int'(addr8), -1);
        end else begin
          e8 = q8.pop_front();
          check("wr8_addr", int'(addr8), e8.a);
          check("wr8_data", int'(data_w8), e8.d);
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_gap = cyc - last_wr;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge P_clk);
  endtask

  task automatic pulse_req(input bit f, input bit c);
    fill_req    = f;
    capture_req = c;
    tick(1);
    fill_req    = 1'b0;
    capture_req = 1'b0;
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick(3);
    VSYNC = 1'b0;
    tick(3);
  endtask

  task automatic new_frame();
    mrow = 0;
    mcol = 0;
  endtask

  task automatic send_line(input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input bit on,
                           input int x3 = -1, input int x8 = -1);
    HREF = 1'b1;
    for (int p = 0; p < n; p++) begin
      D = b0;
      tick(1);
      D = b1;
      if (on && mcol < H && mrow < V)
        push(mrow * H + mcol,
             (x3 < 0) ? f3(b0, b1) : x3,
             (x8 < 0) ? f8(b0, b1) : x8);
      mcol++;
      tick(1);
    end
    HREF = 1'b0;
    D    = 8'h00;
    if (mcol > 0) mrow++;
    mcol = 0;
    tick(4);
  endtask

  task automatic wait_done(input string tag, input int from, input int limit);
    for (int i = 0; i < limit && done_cnt == from; i++) tick(1);
    tick(3);
    check(tag, done_cnt - from, 1);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic fill_frame(input string tag, input bit also_cap);
    base = done_cnt;
    for (int i = 0; i < H * V; i++) push(i, 0, 0);
    pulse_req(1'b1, also_cap);
    check({tag, "_busy_rise"}, int'(busy), 1);
    check({tag, "_no_early_wr"}, int'(regwrite), 0);
    wait_done(tag, base, 40);
    check({tag, "_done_gap"}, done_gap, 1);
    check({tag, "_q3_left"}, q3.size(), 0);
    check({tag, "_q8_left"}, q8.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_regwrite", int'(regwrite), 0);
    check("rst_data", int'(data_w), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_short", int'(short_frame), 0);
    check("rst_busy8", int'(busy8), 0);
    check("rst_done8", int'(frame_done8), 0);
    check("rst_short8", int'(short_frame8), 0);
    rst_n = 1'b1;
    tick(3);

    fill_frame("fill", 1'b0);

    // RGB111 and RGB332 captures, complete 4x2 frames
    base = done_cnt;
    pulse_req(1'b0, 1'b1);
    check("cap_busy_rise", int'(busy), 1);
    vsync_pulse();
    new_frame();
    send_line(4, 8'h84, 8'h10, 1'b1, 7);
    send_line(4, 8'h84, 8'h10, 1'b1, 7);
    wait_done("cap111", base, 100);
    check("cap111_short", int'(short_frame), 0);
    check("cap111_q3_left", q3.size(), 0);
    check("cap111_q8_left", q8.size(), 0);

    base = done_cnt;
    pulse_req(1'b0, 1'b1);
    vsync_pulse();
    new_frame();
    send_line(4, 8'hA5, 8'h18, 1'b1, 7, 8'hB7);
    send_line(4, 8'hA5, 8'h18, 1'b1, 7, 8'hB7);
    wait_done("cap332", base, 100);
    check("cap332_q8_left", q8.size(), 0);

    // request arrives while a line is already streaming
    base = done_cnt;
    HREF = 1'b1;
    D = 8'h84;
    capture_req = 1'b1;
    tick(1);
    capture_req = 1'b0;
    D = 8'h10;
    tick(1);
    send_line(3, 8'h84, 8'h10, 1'b0);
    check("mid_busy", int'(busy), 1);
    check("mid_q3_left", q3.size(), 0);
    vsync_pulse();
    new_frame();
    send_line(4, 8'hC6, 8'h0A, 1'b1);
    send_line(4, 8'h3B, 8'hF1, 1'b1);
    wait_done("mid", base, 100);
    check("mid_q3_empty", q3.size(), 0);

    // short first line, frame ended by VSYNC
    base = done_cnt;
    pulse_req(1'b0, 1'b1);
    vsync_pulse();
    new_frame();
    send_line(3, 8'h84, 8'h10, 1'b1);
    send_line(4, 8'h21, 8'h08, 1'b1);
    VSYNC = 1'b1;
    wait_done("short", base, 50);
    VSYNC = 1'b0;
    tick(3);
    check("short_flag", int'(short_frame), 1);
    check("short_flag8", int'(short_frame8), 1);
    check("short_q3_left", q3.size(), 0);

    // over-long line is truncated; short flag cleared on accept
    base = done_cnt;
    pulse_req(1'b0, 1'b1);
    check("short_cleared", int'(short_frame), 0);
    vsync_pulse();
    new_frame();
    send_line(6, 8'hE7, 8'h1F, 1'b1);
    send_line(4, 8'h42, 8'h13, 1'b1);
    wait_done("long", base, 100);
    check("long_short", int'(short_frame), 0);
    check("long_q3_left", q3.size(), 0);

    fill_frame("both_req", 1'b1);

    // reset in the middle of a capture
    pulse_req(1'b0, 1'b1);
    vsync_pulse();
    new_frame();
    send_line(2, 8'h84, 8'h10, 1'b1);
    HREF = 1'b1;
    D = 8'h84;
    tick(1);
    D = 8'h10;
    tick(1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_regwrite", int'(regwrite), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_addr", int'(addr), 0);
    check("rst_mid_done", int'(frame_done), 0);
    HREF = 1'b0;
    D = 8'h00;
    tick(4);
    rst_n = 1'b1;
    tick(6);
    check("rst_mid_q3_left", q3.size(), 0);
    check("rst_mid_idle", int'(busy), 0);

    fill_frame("post_rst_fill", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
